// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM state encoding,
// drain length and the NOP word that flush/bubble consumers load.
package pipe_ctrl_pkg;

    localparam int NB_STATE = 3;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam int NB_DRAIN     = 2;
    localparam int DRAIN_CYCLES = 3;
    localparam logic [NB_DRAIN-1:0] DRAIN_LAST = NB_DRAIN'(DRAIN_CYCLES - 1);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipeline_ctrl_unit_load_use_detector.sv
// Combinational load-use hazard compare: a load in EX whose destination feeds
// an operand of the instruction in ID cannot be covered by forwarding.
module load_use_detector #(
    parameter int NB_ADDR = 5
) (
    input  logic               mem_read,
    input  logic [NB_ADDR-1:0] rt_ex,
    input  logic [NB_ADDR-1:0] rs_id,
    input  logic [NB_ADDR-1:0] rt_id,
    output logic               stall
);

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign stall = mem_read && (rt_ex != '0) && ((rt_ex == rs_id) || (rt_ex == rt_id));

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Pipeline sequencing controller: stage enables, IF/ID flush, ID/EX bubble,
// debug run/step and HALT drain. Optional perf counters via PIPE_CTRL_PERF_CNT_EN.
module pipeline_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int NB_ADDR = 5
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    parameter int NB_CNT  = 32
`endif
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_ADDR-1:0] i_rf_rs_from_id_unit,
    input  logic [NB_ADDR-1:0] i_rf_rt_from_id_unit,
    input  logic [NB_ADDR-1:0] i_rf_rt_from_ex_unit,
    input  logic               i_mem_read_from_ex_unit,
    input  logic               i_branch_taken,
    input  logic               i_halt_from_id_unit,
    input  logic               i_debug_run,
    input  logic               i_debug_step,
    output logic               o_pc_enb,
    output logic               o_if_id_enb,
    output logic               o_if_id_flush,
    output logic               o_id_ex_bubble,
    output logic               o_pipe_enb,
    output logic               o_halted
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [NB_CNT-1:0]  o_cycle_count,
    output logic [NB_CNT-1:0]  o_stall_count
`endif
);

    state_t              state;
    state_t              state_next;
    logic [NB_DRAIN-1:0] drain_cnt;
    logic                hazard;

    load_use_detector #(
        .NB_ADDR (NB_ADDR)
    ) u_load_use_detector (
        .mem_read (i_mem_read_from_ex_unit),
        .rt_ex    (i_rf_rt_from_ex_unit),
        .rs_id    (i_rf_rs_from_id_unit),
        .rt_id    (i_rf_rt_from_id_unit),
        .stall    (hazard)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counts DRAIN cycles so HALT's predecessors reach WB before we stop.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            drain_cnt <= '0;
        end else if (state == ST_DRAIN) begin
            drain_cnt <= drain_cnt + NB_DRAIN'(1);
        end else begin
            drain_cnt <= '0;
        end
    end

    // Stall outranks HALT, which outranks the branch flush; all are recomputed each cycle.
    always_comb begin
        state_next     = state;
        o_pc_enb       = 1'b0;
        o_if_id_enb    = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_bubble = 1'b0;
        o_pipe_enb     = 1'b0;
        o_halted       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_debug_run) begin
                    state_next = ST_RUN;
                end else if (i_debug_step) begin
                    state_next = ST_STEP;
                end
            end

            ST_RUN, ST_STEP: begin
                o_pipe_enb = 1'b1;
                if (hazard) begin
                    o_id_ex_bubble = 1'b1;
                end else begin
                    o_pc_enb      = 1'b1;
                    o_if_id_enb   = 1'b1;
                    o_if_id_flush = i_branch_taken && !i_halt_from_id_unit;
                end

                if (!hazard && i_halt_from_id_unit) begin
                    state_next = ST_DRAIN;
                end else if (state == ST_STEP || !i_debug_run) begin
                    state_next = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                o_if_id_enb   = 1'b1;
                o_if_id_flush = 1'b1;
                o_pipe_enb    = 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    state_next = ST_HALTED;
                end
            end

            ST_HALTED: begin
                o_halted = 1'b1;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic stall_active;

    assign stall_active = hazard && ((state == ST_RUN) || (state == ST_STEP));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_cycle_count <= '0;
            o_stall_count <= '0;
        end else begin
            if (o_pipe_enb) begin
                o_cycle_count <= o_cycle_count + NB_CNT'(1);
            end
            if (stall_active) begin
                o_stall_count <= o_stall_count + NB_CNT'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Self-checking bench for pipeline_ctrl_unit: directed cycles push expected
// outputs to a scoreboard queue, popped and compared once the outputs settle.
module tb_pipeline_ctrl_unit;

    localparam int NB_ADDR = 5;
    localparam int NB_CNT  = 32;

    logic               i_clock;
    logic               i_reset;
    logic [NB_ADDR-1:0] i_rf_rs_from_id_unit;
    logic [NB_ADDR-1:0] i_rf_rt_from_id_unit;
    logic [NB_ADDR-1:0] i_rf_rt_from_ex_unit;
    logic               i_mem_read_from_ex_unit;
    logic               i_branch_taken;
    logic               i_halt_from_id_unit;
    logic               i_debug_run;
    logic               i_debug_step;
    logic               o_pc_enb;
    logic               o_if_id_enb;
    logic               o_if_id_flush;
    logic               o_id_ex_bubble;
    logic               o_pipe_enb;
    logic               o_halted;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [NB_CNT-1:0]  o_cycle_count;
    logic [NB_CNT-1:0]  o_stall_count;
`endif

    pipeline_ctrl_unit #(
        .NB_ADDR (NB_ADDR)
`ifdef PIPE_CTRL_PERF_CNT_EN
        ,
        .NB_CNT  (NB_CNT)
`endif
    ) dut (
        .i_clock                 (i_clock),
        .i_reset                 (i_reset),
        .i_rf_rs_from_id_unit    (i_rf_rs_from_id_unit),
        .i_rf_rt_from_id_unit    (i_rf_rt_from_id_unit),
        .i_rf_rt_from_ex_unit    (i_rf_rt_from_ex_unit),
        .i_mem_read_from_ex_unit (i_mem_read_from_ex_unit),
        .i_branch_taken          (i_branch_taken),
        .i_halt_from_id_unit     (i_halt_from_id_unit),
        .i_debug_run             (i_debug_run),
        .i_debug_step            (i_debug_step),
        .o_pc_enb                (o_pc_enb),
        .o_if_id_enb             (o_if_id_enb),
        .o_if_id_flush           (o_if_id_flush),
        .o_id_ex_bubble          (o_id_ex_bubble),
        .o_pipe_enb              (o_pipe_enb),
        .o_halted                (o_halted)
`ifdef PIPE_CTRL_PERF_CNT_EN
        ,
        .o_cycle_count           (o_cycle_count),
        .o_stall_count           (o_stall_count)
`endif
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    // Output vector order: {pc_enb, if_id_enb, if_id_flush, id_ex_bubble, pipe_enb, halted}
    localparam logic [5:0] OUT_OFF   = 6'b000000;
    localparam logic [5:0] OUT_RUN   = 6'b110010;
    localparam logic [5:0] OUT_STALL = 6'b000110;
    localparam logic [5:0] OUT_FLUSH = 6'b111010;
    localparam logic [5:0] OUT_DRAIN = 6'b011010;
    localparam logic [5:0] OUT_HALT  = 6'b000001;

    typedef struct {
        string      tag;
        logic [5:0] outs;
    } sb_entry_t;

    sb_entry_t scoreboard[$];
    int        compared   = 0;
    int        mismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle's inputs at the falling edge, queues the expected outputs,
    // then pops and checks them once the combinational outputs have settled.
    task automatic applyStimulus(input string tag, input logic rst, input logic run, input logic step,
                                 input logic mem_read, input logic [NB_ADDR-1:0] rt_ex,
                                 input logic [NB_ADDR-1:0] rs_id, input logic [NB_ADDR-1:0] rt_id,
                                 input logic branch, input logic halt, input logic [5:0] expected);
        sb_entry_t entry;
        @(negedge i_clock);
        i_reset                 = rst;
        i_debug_run             = run;
        i_debug_step            = step;
        i_mem_read_from_ex_unit = mem_read;
        i_rf_rt_from_ex_unit    = rt_ex;
        i_rf_rs_from_id_unit    = rs_id;
        i_rf_rt_from_id_unit    = rt_id;
        i_branch_taken          = branch;
        i_halt_from_id_unit     = halt;
        scoreboard.push_back('{tag: tag, outs: expected});
        #2;
        entry = scoreboard.pop_front();
        checkOutput(entry.tag, 32'({o_pc_enb, o_if_id_enb, o_if_id_flush, o_id_ex_bubble, o_pipe_enb, o_halted}),
                    32'(entry.outs));
    endtask

    initial begin
        i_reset                 = 1'b1;
        i_debug_run             = 1'b0;
        i_debug_step            = 1'b0;
        i_mem_read_from_ex_unit = 1'b0;
        i_rf_rt_from_ex_unit    = '0;
        i_rf_rs_from_id_unit    = '0;
        i_rf_rt_from_id_unit    = '0;
        i_branch_taken          = 1'b0;
        i_halt_from_id_unit     = 1'b0;
        repeat (2) @(posedge i_clock);

        //            tag              rst run stp mr  rtex rsid rtid br  hlt expected
        applyStimulus("reset",          1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, OUT_OFF);
`ifdef PIPE_CTRL_PERF_CNT_EN
        checkOutput("reset_cycle_cnt", o_cycle_count, 32'd0);
        checkOutput("reset_stall_cnt", o_stall_count, 32'd0);
`endif
        applyStimulus("idle_run_req",   0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, OUT_OFF);
        applyStimulus("run",            0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, OUT_RUN);
        applyStimulus("stall_rs",       0, 1, 0, 1, 5'd5, 5'd5, 5'd1, 0, 0, OUT_STALL);
        applyStimulus("stall_rt",       0, 1, 0, 1, 5'd5, 5'd3, 5'd5, 0, 0, OUT_STALL);
        applyStimulus("rt0_no_stall",   0, 1, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, OUT_RUN);
        applyStimulus("no_load_match",  0, 1, 0, 0, 5'd5, 5'd5, 5'd5, 0, 0, OUT_RUN);
        applyStimulus("load_no_match",  0, 1, 0, 1, 5'd7, 5'd3, 5'd4, 0, 0, OUT_RUN);
        applyStimulus("branch_stall",   0, 1, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, OUT_STALL);
        applyStimulus("branch_flush",   0, 1, 0, 0, 5'd5, 5'd5, 5'd0, 1, 0, OUT_FLUSH);
        applyStimulus("halt_stall",     0, 1, 1, 1, 5'd9, 5'd2, 5'd9, 0, 1, OUT_STALL);
        applyStimulus("halt_run",       0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, OUT_RUN);
`ifdef PIPE_CTRL_PERF_CNT_EN
        checkOutput("run_cycle_cnt", o_cycle_count, 32'd9);
        checkOutput("run_stall_cnt", o_stall_count, 32'd4);
`endif
        applyStimulus("drain_0",        0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, OUT_DRAIN);
        applyStimulus("drain_1",        0, 1, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, OUT_DRAIN);
        applyStimulus("drain_2",        0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, OUT_DRAIN);
        applyStimulus("halted",         0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, OUT_HALT);
        applyStimulus("halted_hold",    0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, OUT_HALT);
        applyStimulus("reset_in_halt",  1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, OUT_HALT);
        applyStimulus("idle_after_rst", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, OUT_OFF);
        applyStimulus("step_req",       0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, OUT_OFF);
        applyStimulus("step_cycle",     0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, OUT_RUN);
        applyStimulus("step_done",      0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, OUT_OFF);
`ifdef PIPE_CTRL_PERF_CNT_EN
        checkOutput("step_cycle_cnt", o_cycle_count, 32'd1);
`endif
        applyStimulus("run_and_step",   0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, OUT_OFF);
        applyStimulus("run_wins",       0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, OUT_RUN);
        applyStimulus("run_drop",       0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, OUT_RUN);
        applyStimulus("idle_again",     0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, OUT_OFF);
        applyStimulus("step_req2",      0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, OUT_OFF);
        applyStimulus("step_halt",      0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, OUT_RUN);
        applyStimulus("step_drain",     0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, OUT_DRAIN);
        applyStimulus("rst_mid_drain",  1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, OUT_DRAIN);
        applyStimulus("idle_post_rst",  0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, OUT_OFF);
`ifdef PIPE_CTRL_PERF_CNT_EN
        checkOutput("rst_cycle_cnt", o_cycle_count, 32'd0);
        checkOutput("rst_stall_cnt", o_stall_count, 32'd0);
`endif
        applyStimulus("idle_stays",     0, 0, 0, 1, 5'd5, 5'd5, 5'd5, 1, 1, OUT_OFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
